// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_txd among NUM_REQ byte sources.
// Grants a source, latches its byte, pulses ena, then follows rts through the frame.
module uart_tx_arbiter #(
  parameter int  NUM_REQ      = 4,
  parameter int  BUSY_TIMEOUT = 16,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_d_o,
  output logic                 tx_ena_o,
  input  logic                 tx_rts_i,
  output logic [IDX_W-1:0]     grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [7:0]       tx_d_q, tx_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rr_pick;
  logic             rr_found;

  // First valid source strictly after rr_ptr_q; the modulo keeps non-power-of-two counts in range.
  always_comb begin
    int idx;
    idx      = 0;
    rr_pick  = rr_ptr_q;
    rr_found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(rr_ptr_q) + off) % NUM_REQ;
      if (!rr_found && req_valid_i[IDX_W'(idx)]) begin
        rr_found = 1'b1;
        rr_pick  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    grant_d     = grant_q;
    tx_d_d      = tx_d_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    tx_ena_o    = 1'b0;
    timeout_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr_found && tx_rts_i) begin
          winner_d = rr_pick;
          state_d  = ACCEPT;
        end
      end
      ACCEPT: begin
        // The pointer advances even when the source withdrew, so it loses priority either way.
        req_ready_o[winner_q] = 1'b1;
        tx_d_d   = req_data_i[{winner_q, 3'b000} +: 8];
        grant_d  = winner_q;
        rr_ptr_d = winner_q;
        state_d  = req_valid_i[winner_q] ? START : IDLE;
      end
      START: begin
        tx_ena_o = 1'b1;
        cnt_d    = CNT_W'(1);
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_rts_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT)) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_rts_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      winner_q <= '0;
      grant_q  <= '0;
      tx_d_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      grant_q  <= grant_d;
      tx_d_q   <= tx_d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tx_d_o  = tx_d_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued sources, a uart_txd rts model and a
// round-robin reference that predicts the grant/byte sequence of every burst.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_d;
  logic           tx_ena;
  logic           tx_rts = 1'b1;
  logic [1:0]     grant;
  logic           busy;
  logic           timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TMO)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .tx_d_o(tx_d), .tx_ena_o(tx_ena), .tx_rts_i(tx_rts),
    .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
  );

  typedef struct { logic [7:0] data; bit wd; } ent_t;
  typedef struct { int src; logic [7:0] data; } exp_t;

  ent_t src_q[N][$];
  int   ready_exp[$];
  exp_t ena_exp[$];
  bit   take_pend[N];
  bit   hold[N];
  bit   tx_dead = 1'b0;
  int   m_rr = N - 1;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, last_ena = -1000, last_ready = -1000, n_tmo = 0, n_ena = 0;
  int   e_src;
  exp_t e_ena;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = (src_q[i].size() > 0) && !hold[i];
      req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0].data : 8'h00;
    end
  endtask

  task automatic push(int s, logic [7:0] d, bit wd);
    ent_t e;
    e.data = d;
    e.wd   = wd;
    src_q[s].push_back(e);
  endtask

  // Reference: serve pending bytes one at a time, always the first pending source after the last winner.
  task automatic predict();
    int pos[N];
    int idx;
    bit got;
    exp_t x;
    for (int i = 0; i < N; i++) pos[i] = 0;
    do begin
      got = 1'b0;
      for (int off = 1; off <= N && !got; off++) begin
        idx = (m_rr + off) % N;
        if (pos[idx] < src_q[idx].size()) begin
          got = 1'b1;
          ready_exp.push_back(idx);
          if (!src_q[idx][pos[idx]].wd) begin
            x.src  = idx;
            x.data = src_q[idx][pos[idx]].data;
            ena_exp.push_back(x);
          end
          pos[idx]++;
          m_rr = idx;
        end
      end
    end while (got);
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return (ready_exp.size() == 0) && (ena_exp.size() == 0);
  endfunction

  task automatic wait_drain(string name);
    int k = 0;
    while ((!all_empty() || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL %s: drain not reached after %0d cycles, %0d grants outstanding", name, k, ready_exp.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_ena"}, tx_ena, 0);
    check({tag, "_tx_d"}, tx_d, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // Source side: a byte leaves its queue once valid&ready met at a clock edge; withdrawn bytes drop valid at once.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    if (!arst_n) begin
      for (int i = 0; i < N; i++) take_pend[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (take_pend[i]) begin
          src_q[i].delete(0);
          take_pend[i] = 1'b0;
        end else if (req_ready[i] && src_q[i].size() > 0) begin
          if (src_q[i][0].wd) begin
            src_q[i].delete(0);
            hold[i] = 1'b1;
          end else begin
            take_pend[i] = 1'b1;
          end
        end
      end
    end
    drive();
  end

  // uart_txd model: rts falls a few cycles after ena and stays low for one frame.
  initial forever begin
    @(negedge clk);
    if (tx_ena && !tx_dead && arst_n) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      tx_rts = 1'b0;
      repeat ($urandom_range(5, 12)) @(negedge clk);
      tx_rts = 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant, an ena or a timeout.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (arst_n) begin
      if (req_ready != 0) begin
        check("ready_onehot", $countones(req_ready), 1);
        check("ready_with_ena", tx_ena, 0);
        if (ready_exp.size() == 0) begin
          check("ready_unexpected", req_ready, 0);
        end else begin
          e_src = ready_exp.pop_front();
          check("ready_src", req_ready, 32'd1 << e_src);
        end
        last_ready = cyc;
      end
      if (tx_ena) begin
        n_ena++;
        check("ena_after_ready", cyc - last_ready, 1);
        check("busy_at_ena", busy, 1);
        if (ena_exp.size() == 0) begin
          check("ena_unexpected", tx_ena, 0);
        end else begin
          e_ena = ena_exp.pop_front();
          $display("frame src=%0d tx_d=%02h grant=%0d (expected src=%0d byte=%02h)", e_ena.src, tx_d, grant, e_ena.src, e_ena.data);
          check("tx_d", tx_d, e_ena.data);
          check("grant", grant, e_ena.src);
        end
        last_ena = cyc;
      end
      if (timeout) begin
        n_tmo++;
        check("timeout_delay", cyc - last_ena, TMO);
        check("timeout_expected", tx_dead, 1);
      end
    end
  end

  initial begin
    #2ms;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int k;
    int ena_before;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four continuously valid from reset: 10,11,12,13,10.
    push(0, 8'h10, 0); push(0, 8'h10, 0);
    push(1, 8'h11, 0); push(2, 8'h12, 0); push(3, 8'h13, 0);
    predict();
    wait_drain("all_four");

    push(2, 8'h48, 0);
    predict();
    wait_drain("single_src2");

    // Fairness: after grant 1, sources 1 and 3 -> 3 then 1.
    push(1, 8'h21, 0);
    predict();
    wait_drain("fair_a");
    push(1, 8'h31, 0); push(3, 8'h33, 0);
    predict();
    wait_drain("fair_b");

    // Transmitter never drops rts.
    tx_dead = 1'b1;
    push(0, 8'hA5, 0);
    predict();
    wait_drain("timeout");
    check("timeout_count", n_tmo, 1);
    tx_dead = 1'b0;
    push(1, 8'h5A, 0);
    predict();
    wait_drain("after_timeout");

    // Withdrawal in ACCEPT: no ena, busy drops next cycle, pointer still moves to 2.
    push(2, 8'hC3, 1);
    predict();
    k = 0;
    while (!req_ready[2] && k < 50) begin @(negedge clk); k++; end
    check("withdraw_ready_seen", req_ready[2], 1);
    @(negedge clk);
    check("withdraw_busy_low", busy, 0);
    wait_drain("withdraw");
    push(2, 8'h62, 0); push(3, 8'h63, 0);
    predict();
    wait_drain("after_withdraw");

    // Reset in WAIT_DONE.
    push(1, 8'h77, 0);
    predict();
    k = 0;
    while (tx_rts && k < 50) begin @(negedge clk); k++; end
    check("frame_rts_low", tx_rts, 0);
    repeat (2) @(negedge clk);
    check("busy_in_frame", busy, 1);
    #2 arst_n = 1'b0;
    m_rr = N - 1;
    #1 check_reset_outputs("mid");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    ena_before = n_ena;
    repeat (25) @(negedge clk);
    check("no_ena_after_reset", n_ena, ena_before);
    push(0, 8'h80, 0); push(3, 8'h83, 0);
    predict();
    wait_drain("after_reset");

    // Randomized bursts.
    for (int b = 0; b < 40; b++) begin
      int pushed = 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
            push(i, 8'($urandom), ($urandom_range(0, 7) == 0));
            pushed++;
          end
        end
      end
      if (pushed == 0) push(int'($urandom_range(0, N - 1)), 8'($urandom), 0);
      predict();
      wait_drain("random");
    end

    check("final_timeout_count", n_tmo, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
